// File: rtl/buzzer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// buzzer_sequencer_pkg
//
// Purpose
//   Shared definitions for the quiz-buzzer tone sequencer: the state
//   encoding used by the sequencer FSM, the width of the beep index and
//   the default tone durations (chosen for a 50 MHz system clock).
//
// Contents
//   state_t            2-bit state type
//   ST_IDLE .. ST_TO_GAP  state encoding constants
//   DEF_*              default parameter values for buzzer_sequencer
//   IDX_W              width of the time-over beep index (counts 1..7)
// ---------------------------------------------------------------------------
package buzzer_sequencer_pkg;

    // State encoding kept as plain constants so the FSM register can be
    // probed and compared as a bare vector by older tools.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ANS     = 2'd1;
    localparam state_t ST_TO_BEEP = 2'd2;
    localparam state_t ST_TO_GAP  = 2'd3;

    // Default durations in clock cycles at 50 MHz.
    localparam int unsigned DEF_ANS_ON   = 25000000;  // 0.5 s answer beep
    localparam int unsigned DEF_TO_ON    = 10000000;  // 0.2 s time-over beep
    localparam int unsigned DEF_TO_OFF   = 10000000;  // 0.2 s gap between beeps
    localparam int unsigned DEF_TO_BEEPS = 3;         // beeps per time-over
    localparam int unsigned DEF_CNT_W    = 25;        // holds 25_000_000 - 1

    // The beep index only ever needs to reach 7.
    localparam int unsigned IDX_W = 3;

endpackage : buzzer_sequencer_pkg

// File: rtl/buzzer_sequencer_beat_timer.sv
// ---------------------------------------------------------------------------
// beat_timer
//
// Purpose
//   Down-counter that measures the length of one sequencer phase. On load
//   it takes (duration - 1); it then counts down once per clock and holds
//   at zero. expire_o is high while the count is zero, i.e. during the last
//   cycle of the phase, so a phase of N cycles spends exactly N cycles
//   between its load edge and the edge that leaves it.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-high reset, clears the count
//   load_i      start a new phase (has priority over counting)
//   duration_i  phase length in cycles, sampled when load_i is high
//   expire_o    high while the count is zero (last cycle of the phase)
// ---------------------------------------------------------------------------
module beat_timer #(
    parameter int unsigned CNT_W = 25
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] duration_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a zero-length request is clamped to zero instead of being
    // allowed to underflow, and a running count stops at zero so it can
    // never wrap back to the top of the range.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            if (duration_i == '0) begin
                count_d = '0;
            end else begin
                count_d = duration_i - CNT_W'(1);
            end
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == '0);

endmodule : beat_timer

// File: rtl/buzzer_sequencer.sv
// ---------------------------------------------------------------------------
// buzzer_sequencer
//
// Purpose
//   Drives the two tone requests of a quiz buzzer. An answer event plays a
//   single long answer beep; a time-over event plays TO_BEEPS short beeps
//   separated by gaps. An answer always wins: it pre-empts a running
//   time-over pattern, and a time-over arriving during an answer beep is
//   remembered and played once the answer beep finishes. Mute silences the
//   requests without disturbing any timing.
//
// Ports
//   CLK              system clock, rising edge
//   RST              asynchronous active-high reset
//   Answer_Evt       one-cycle pulse, first contestant locked in
//   TimeOver_Evt     one-cycle pulse, countdown expired
//   Mute             level, suppress both tone requests
//   Buzzer_Answer    registered answer-tone request
//   Buzzer_TimeOver  registered time-over-tone request
//   Busy             registered, high while a sequence runs or is pending
// ---------------------------------------------------------------------------
module buzzer_sequencer
    import buzzer_sequencer_pkg::*;
#(
    parameter int unsigned ANS_ON   = DEF_ANS_ON,
    parameter int unsigned TO_ON    = DEF_TO_ON,
    parameter int unsigned TO_OFF   = DEF_TO_OFF,
    parameter int unsigned TO_BEEPS = DEF_TO_BEEPS,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic Answer_Evt,
    input  logic TimeOver_Evt,
    input  logic Mute,
    output logic Buzzer_Answer,
    output logic Buzzer_TimeOver,
    output logic Busy
);

    localparam logic [CNT_W-1:0] ANS_DUR    = CNT_W'(ANS_ON);
    localparam logic [CNT_W-1:0] TO_ON_DUR  = CNT_W'(TO_ON);
    localparam logic [CNT_W-1:0] TO_OFF_DUR = CNT_W'(TO_OFF);
    localparam logic [IDX_W-1:0] LAST_BEEP  = IDX_W'(TO_BEEPS);
    localparam logic [IDX_W-1:0] FIRST_BEEP = IDX_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             pend_q;
    logic             pend_d;

    logic             ans_q;
    logic             to_q;
    logic             busy_q;

    logic             timer_load;
    logic [CNT_W-1:0] timer_dur;
    logic             timer_expire;

    beat_timer #(
        .CNT_W (CNT_W)
    ) u_beat_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (timer_load),
        .duration_i (timer_dur),
        .expire_o   (timer_expire)
    );

    // Sequencer next-state logic. Every state entry also loads the timer
    // with the length of the state being entered, so the timer value is
    // always relative to the current phase.
    //
    // The final beep of a time-over pattern returns straight to IDLE: a gap
    // after it would be silent and would only keep Busy asserted for no
    // audible reason. Gaps therefore only separate consecutive beeps.
    //
    // A time-over seen on the very cycle the answer beep expires still
    // counts as pending, so it is folded into the exit decision directly.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        timer_load = 1'b0;
        timer_dur  = '0;

        case (state_q)
            ST_IDLE: begin
                if (Answer_Evt) begin
                    state_d    = ST_ANS;
                    pend_d     = TimeOver_Evt;
                    timer_load = 1'b1;
                    timer_dur  = ANS_DUR;
                end else if (TimeOver_Evt) begin
                    state_d    = ST_TO_BEEP;
                    idx_d      = FIRST_BEEP;
                    timer_load = 1'b1;
                    timer_dur  = TO_ON_DUR;
                end
            end

            ST_ANS: begin
                if (TimeOver_Evt) begin
                    pend_d = 1'b1;
                end
                if (timer_expire) begin
                    pend_d = 1'b0;
                    if (pend_q || TimeOver_Evt) begin
                        state_d    = ST_TO_BEEP;
                        idx_d      = FIRST_BEEP;
                        timer_load = 1'b1;
                        timer_dur  = TO_ON_DUR;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end
                end
            end

            ST_TO_BEEP: begin
                if (Answer_Evt) begin
                    state_d    = ST_ANS;
                    idx_d      = '0;
                    pend_d     = 1'b0;
                    timer_load = 1'b1;
                    timer_dur  = ANS_DUR;
                end else if (timer_expire) begin
                    if (idx_q < LAST_BEEP) begin
                        state_d    = ST_TO_GAP;
                        timer_load = 1'b1;
                        timer_dur  = TO_OFF_DUR;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end
                end
            end

            ST_TO_GAP: begin
                if (Answer_Evt) begin
                    state_d    = ST_ANS;
                    idx_d      = '0;
                    pend_d     = 1'b0;
                    timer_load = 1'b1;
                    timer_dur  = ANS_DUR;
                end else if (timer_expire) begin
                    state_d    = ST_TO_BEEP;
                    idx_d      = idx_q + FIRST_BEEP;
                    timer_load = 1'b1;
                    timer_dur  = TO_ON_DUR;
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // FSM registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // Output registers are fed from the next state so a request rises on
    // the same edge that enters the phase, and falls on the edge that
    // leaves it. The two state decodes are mutually exclusive, so the
    // requests can never overlap. Mute masks only these requests.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ans_q  <= 1'b0;
            to_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ans_q  <= (state_d == ST_ANS) && !Mute;
            to_q   <= (state_d == ST_TO_BEEP) && !Mute;
            busy_q <= (state_d != ST_IDLE) || pend_d;
        end
    end

    assign Buzzer_Answer   = ans_q;
    assign Buzzer_TimeOver = to_q;
    assign Busy            = busy_q;

endmodule : buzzer_sequencer

// File: tb/tb_buzzer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_buzzer_sequencer
//
// Drives buzzer_sequencer with small durations and compares every cycle of
// its outputs against a timeline model: each accepted event schedules the
// cycle ranges in which tones should sound, and expected outputs are read
// off those ranges with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_buzzer_sequencer;

    localparam int ANS_ON   = 8;
    localparam int TO_ON    = 4;
    localparam int TO_OFF   = 3;
    localparam int TO_BEEPS = 3;
    localparam int CNT_W    = 8;
    localparam int TO_LEN   = TO_BEEPS * TO_ON + (TO_BEEPS - 1) * TO_OFF;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic Answer_Evt = 1'b0;
    logic TimeOver_Evt = 1'b0;
    logic Mute = 1'b0;
    logic Buzzer_Answer;
    logic Buzzer_TimeOver;
    logic Busy;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Timeline model: inclusive cycle ranges of the answer beep and of the
    // whole time-over pattern; start > end means nothing scheduled.
    int  ansStart = 1, ansEnd = 0;
    int  toStart = 1, toEnd = 0;
    bit  pendingTo = 0;

    int  hiAns, hiTo, hiBusy;

    buzzer_sequencer #(
        .ANS_ON   (ANS_ON),
        .TO_ON    (TO_ON),
        .TO_OFF   (TO_OFF),
        .TO_BEEPS (TO_BEEPS),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .Answer_Evt      (Answer_Evt),
        .TimeOver_Evt    (TimeOver_Evt),
        .Mute            (Mute),
        .Buzzer_Answer   (Buzzer_Answer),
        .Buzzer_TimeOver (Buzzer_TimeOver),
        .Busy            (Busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit inAns(int c);
        return (c >= ansStart) && (c <= ansEnd);
    endfunction

    function automatic bit inTo(int c);
        return (c >= toStart) && (c <= toEnd);
    endfunction

    function automatic bit beepOn(int c);
        return inTo(c) && (((c - toStart) % (TO_ON + TO_OFF)) < TO_ON);
    endfunction

    task automatic scheduleTo(int s);
        toStart = s;
        toEnd   = s + TO_LEN - 1;
    endtask

    task automatic modelClear();
        ansStart = 1; ansEnd = 0;
        toStart = 1;  toEnd = 0;
        pendingTo = 0;
    endtask

    // Apply the events sampled at the end of cycle t to the timeline.
    task automatic modelStep(int t, bit a, bit o);
        if (inAns(t)) begin
            if (o && !pendingTo) begin
                scheduleTo(ansEnd + 1);
                pendingTo = 1;
            end
        end else if (inTo(t)) begin
            if (a) begin
                toEnd     = t;
                ansStart  = t + 1;
                ansEnd    = t + ANS_ON;
                pendingTo = 0;
            end
        end else begin
            if (a) begin
                ansStart  = t + 1;
                ansEnd    = t + ANS_ON;
                pendingTo = 0;
                if (o) begin
                    scheduleTo(ansEnd + 1);
                    pendingTo = 1;
                end
            end else if (o) begin
                scheduleTo(t + 1);
            end
        end
    endtask

    task automatic compareBit(string tag, logic observed, logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, observed, expected);
        end
    endtask

    task automatic compareInt(string tag, int observed, int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(bit m);
        compareBit("answer", Buzzer_Answer, inAns(cyc) && !m);
        compareBit("timeover", Buzzer_TimeOver, beepOn(cyc) && !m);
        compareBit("busy", Busy, inAns(cyc) || inTo(cyc));
        compareBit("exclusive", Buzzer_Answer && Buzzer_TimeOver, 1'b0);
        hiAns  += int'(Buzzer_Answer);
        hiTo   += int'(Buzzer_TimeOver);
        hiBusy += int'(Busy);
    endtask

    // One clock cycle: drive inputs, let the edge sample them, then check.
    task automatic applyStimulus(bit a, bit o, bit m);
        Answer_Evt   = a;
        TimeOver_Evt = o;
        Mute         = m;
        @(posedge CLK);
        modelStep(cyc, a, o);
        cyc++;
        #1;
        checkOutput(m);
    endtask

    task automatic idleCycles(int n, bit m);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, m);
    endtask

    task automatic clearTally();
        hiAns = 0; hiTo = 0; hiBusy = 0;
    endtask

    // Reset asserted between edges: outputs must clear without a clock.
    task automatic midReset();
        Answer_Evt = 1'b0;
        TimeOver_Evt = 1'b0;
        RST = 1'b1;
        #1;
        compareBit("rst_answer", Buzzer_Answer, 1'b0);
        compareBit("rst_timeover", Buzzer_TimeOver, 1'b0);
        compareBit("rst_busy", Busy, 1'b0);
        modelClear();
        @(posedge CLK);
        cyc++;
        #1;
        compareBit("rst_hold_busy", Busy, 1'b0);
        RST = 1'b0;
    endtask

    initial begin
        bit rm;
        clearTally();
        #2;
        compareBit("init_answer", Buzzer_Answer, 1'b0);
        compareBit("init_timeover", Buzzer_TimeOver, 1'b0);
        compareBit("init_busy", Busy, 1'b0);
        @(posedge CLK); cyc++;
        @(posedge CLK); cyc++;
        #1;
        RST = 1'b0;
        idleCycles(3, 1'b0);

        $display("[TB] single answer");
        clearTally();
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(15, 1'b0);
        compareInt("ans_len", hiAns, 8);
        compareInt("ans_busy_len", hiBusy, 8);

        $display("[TB] single time-over");
        clearTally();
        applyStimulus(1'b0, 1'b1, 1'b0);
        idleCycles(25, 1'b0);
        compareInt("to_len", hiTo, 12);
        compareInt("to_busy_len", hiBusy, 18);

        $display("[TB] both events together");
        clearTally();
        applyStimulus(1'b1, 1'b1, 1'b0);
        idleCycles(35, 1'b0);
        compareInt("both_ans_len", hiAns, 8);
        compareInt("both_to_len", hiTo, 12);
        compareInt("both_busy_len", hiBusy, 26);

        $display("[TB] answer aborts time-over");
        clearTally();
        applyStimulus(1'b0, 1'b1, 1'b0);
        idleCycles(5, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(20, 1'b0);
        compareInt("abort_to_len", hiTo, 4);
        compareInt("abort_ans_len", hiAns, 8);
        compareInt("abort_busy_len", hiBusy, 14);

        $display("[TB] muted time-over");
        clearTally();
        applyStimulus(1'b0, 1'b1, 1'b1);
        idleCycles(25, 1'b1);
        compareInt("mute_to_len", hiTo, 0);
        compareInt("mute_busy_len", hiBusy, 18);

        $display("[TB] reset mid-answer");
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(3, 1'b0);
        midReset();
        clearTally();
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(12, 1'b0);
        compareInt("post_rst_ans_len", hiAns, 8);

        $display("[TB] repeated events while active");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idleCycles(4, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idleCycles(30, 1'b0);

        $display("[TB] randomized traffic");
        rm = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            bit ra, ro;
            ra = ($urandom_range(0, 24) == 0);
            ro = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) rm = !rm;
            if ($urandom_range(0, 299) == 0) begin
                midReset();
            end
            applyStimulus(ra, ro, rm);
        end
        idleCycles(40, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_buzzer_sequencer
